// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg: shared definitions for the generic pipeline-register stages
// (ID/EX, EX/MEM, MEM/WB).
//   - control-vector bit indices and width
//   - default kill mask: the side-effecting control bits that must read 0
//     whenever a stage output is not valid
//   - ID/EX payload field offsets used by the instantiating decode stage
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Control vector layout
    localparam int CTRL_REGDST    = 0;
    localparam int CTRL_BRANCH    = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_MEMTOREG  = 3;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_MEMWRITE  = 5;
    localparam int CTRL_REGWRITE  = 6;
    localparam int CTRL_CONDMOV   = 7;
    localparam int CTRL_ALUOP_LSB = 8;
    localparam int CTRL_ALUOP_W   = 4;
    localparam int CTRL_W         = 12;

    // Bits that change architectural state; a bubble must never assert them.
    localparam logic [CTRL_W-1:0] KILL_MASK_DEFAULT = CTRL_W'(
        (1 << CTRL_BRANCH)   | (1 << CTRL_MEMREAD) | (1 << CTRL_MEMWRITE) |
        (1 << CTRL_REGWRITE) | (1 << CTRL_CONDMOV));

    // ID/EX payload layout (packed by the decode stage)
    localparam int IDEX_RD1_LSB   = 0;
    localparam int IDEX_RD1_W     = 32;
    localparam int IDEX_RD2_LSB   = 32;
    localparam int IDEX_RD2_W     = 32;
    localparam int IDEX_IMM_LSB   = 64;
    localparam int IDEX_IMM_W     = 32;
    localparam int IDEX_RT_LSB    = 96;
    localparam int IDEX_RT_W      = 5;
    localparam int IDEX_RD_LSB    = 101;
    localparam int IDEX_RD_W      = 5;
    localparam int IDEX_PCADD_LSB = 106;
    localparam int IDEX_PCADD_W   = 6;   // low bits of PC+4 carried to EX
    localparam int IDEX_DATA_W    = IDEX_PCADD_LSB + IDEX_PCADD_W;

endpackage

// File: rtl/pipe_skid_reg.sv
// ---------------------------------------------------------------------------
// pipe_skid_reg: one valid bit plus a data word, used both as the main (M)
// and the skid (S) entry of a pipeline stage.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   load       : capture d and mark the entry valid
//   clear      : invalidate the entry (wins over load; data is left as is)
//   d / q      : data in / held data
//   valid      : entry holds a live instruction
// ---------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            valid <= 1'b0;
            // NOTE: the data word is reset as well, so a freshly reset stage
            // presents all-zero payload and control rather than stale bits.
            q     <= '0;
        end else begin
            if (clear) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end
            if (load && !clear) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/idex_pipe_stage.sv
// ---------------------------------------------------------------------------
// idex_pipe_stage: generic valid/ready pipeline register between two stages.
//   Clk, Rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake
//   in_data/in_ctrl     : upstream payload and control vector
//   flush               : synchronous kill of every held entry
//   out_valid/out_ready : downstream handshake (out_ready=0 stalls)
//   out_data/out_ctrl   : downstream payload and control; KILL_MASK bits of
//                         out_ctrl read 0 whenever out_valid is 0
//   occupancy           : number of entries held (0..2)
// SKID=1 adds a second entry so in_ready can come straight from a flop;
// SKID=0 is a single register whose in_ready is combinational.
// ---------------------------------------------------------------------------
module idex_pipe_stage #(
    parameter int                    DATA_W    = pipe_pkg::IDEX_DATA_W,
    parameter int                    CTRL_W    = pipe_pkg::CTRL_W,
    parameter logic [CTRL_W-1:0]     KILL_MASK = CTRL_W'(pipe_pkg::KILL_MASK_DEFAULT),
    parameter bit                    SKID      = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam int W = DATA_W + CTRL_W;

    logic         m_valid, s_valid;
    logic [W-1:0] m_q, s_q, m_d;
    logic         accept, drain;
    logic         m_load, m_clear, s_load, s_clear;

    assign accept = in_valid & in_ready;
    assign drain  = m_valid & out_ready;

    // M refills from S whenever S holds something: S is always the younger
    // entry, and while S is valid no new input can be accepted.
    assign m_d = s_valid ? s_q : {in_ctrl, in_data};

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        if (SKID) begin
            m_load  = (drain & s_valid) | (accept & (!m_valid | drain) & !s_valid);
            m_clear = drain & !s_valid & !accept;
            s_load  = accept & m_valid & !drain;
            s_clear = drain & s_valid;
        end else begin
            m_load  = accept;
            m_clear = drain & !accept;
        end
        // Flush wins over everything: a draining entry still leaves this
        // cycle, but nothing is loaded and both entries empty.
        if (flush) begin
            m_load  = 1'b0;
            s_load  = 1'b0;
            m_clear = 1'b1;
            s_clear = 1'b1;
        end
    end

    pipe_skid_reg #(.W(W)) u_main (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_d),
        .valid (m_valid),
        .q     (m_q)
    );

    pipe_skid_reg #(.W(W)) u_skid (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .load  (s_load),
        .clear (s_clear),
        .d     ({in_ctrl, in_data}),
        .valid (s_valid),
        .q     (s_q)
    );

    generate
        if (SKID) begin : g_reg_ready
            logic ready_q;
            logic s_valid_next;

            assign s_valid_next = !s_clear & (s_load | s_valid);

            // Registered copy of !S.valid; resets low so the stage only
            // starts accepting one cycle after reset release.
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    ready_q <= 1'b0;
                end else begin
                    ready_q <= !s_valid_next;
                end
            end

            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = !m_valid | out_ready;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_data  = m_q[DATA_W-1:0];
    assign out_ctrl  = m_q[W-1:DATA_W] & ~(m_valid ? {CTRL_W{1'b0}} : KILL_MASK);
    assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_idex_pipe_stage.sv
// ---------------------------------------------------------------------------
// Bench for idex_pipe_stage. Two instances (SKID=1 and SKID=0) share one
// stimulus stream; each is tracked by a queue model of the stage.
// ---------------------------------------------------------------------------
module tb_idex_pipe_stage;

    localparam int DW = 112;
    localparam int CW = 12;
    localparam logic [CW-1:0] KILL = 12'h0E6;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } entry_t;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          fl;
        logic          o;
        logic          ev;
        logic [DW-1:0] ed;
        logic [1:0]    eocc;
        logic          eir;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;

    logic          r1_in_ready, r1_out_valid;
    logic [DW-1:0] r1_out_data;
    logic [CW-1:0] r1_out_ctrl;
    logic [1:0]    r1_occ;
    logic          r0_in_ready, r0_out_valid;
    logic [DW-1:0] r0_out_data;
    logic [CW-1:0] r0_out_ctrl;
    logic [1:0]    r0_occ;

    int n_cmp = 0;
    int n_bad = 0;

    // Queue models: q1 for SKID=1, q0 for SKID=0; rdy1 is the registered ready.
    entry_t q1[$];
    entry_t q0[$];
    logic   rdy1 = 1'b0;

    vec_t tbl[18];

    always #5 clk = ~clk;

    idex_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(KILL), .SKID(1'b1)) u_dut1 (
        .Clk(clk), .Rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(r1_out_valid),
        .out_ready(out_ready), .out_data(r1_out_data), .out_ctrl(r1_out_ctrl),
        .occupancy(r1_occ)
    );

    idex_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .KILL_MASK(KILL), .SKID(1'b0)) u_dut0 (
        .Clk(clk), .Rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .out_valid(r0_out_valid),
        .out_ready(out_ready), .out_data(r0_out_data), .out_ctrl(r0_out_ctrl),
        .occupancy(r0_occ)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        rdy1 = 1'b0;
    endtask

    task automatic model_check(input int k, input logic ov, input logic [DW-1:0] od,
                               input logic [CW-1:0] oc, input logic [1:0] occ, input logic ir);
        int     cnt;
        entry_t head;
        logic   eir;
        head = '0;
        if (k == 1) begin
            cnt = q1.size();
            if (cnt > 0) head = q1[0];
            eir = rdy1;
        end else begin
            cnt = q0.size();
            if (cnt > 0) head = q0[0];
            eir = (cnt == 0) || out_ready;
        end
        check($sformatf("m%0d out_valid", k), 128'(ov), 128'(cnt > 0));
        check($sformatf("m%0d occupancy", k), 128'(occ), 128'(cnt));
        check($sformatf("m%0d in_ready", k), 128'(ir), 128'(eir));
        if (cnt > 0) begin
            check($sformatf("m%0d out_data", k), 128'(od), 128'(head.data));
            check($sformatf("m%0d out_ctrl", k), 128'(oc), 128'(head.ctrl));
        end else begin
            check($sformatf("m%0d bubble_ctrl", k), 128'(oc & KILL), 128'(0));
        end
    endtask

    // Wait for the falling edge and compare both instances against the model.
    task automatic sample();
        @(negedge clk);
        model_check(1, r1_out_valid, r1_out_data, r1_out_ctrl, r1_occ, r1_in_ready);
        model_check(0, r0_out_valid, r0_out_data, r0_out_ctrl, r0_occ, r0_in_ready);
    endtask

    // Cross the rising edge and step the model with the inputs seen there.
    task automatic advance();
        logic   v, fl, o, rs, acc, drn;
        entry_t w;
        v  = in_valid;
        fl = flush;
        o  = out_ready;
        rs = rst_n;
        w  = {in_ctrl, in_data};
        acc = ((v && rdy1) != 0);
        drn = (q1.size() > 0) && o;
        @(posedge clk);
        #1;
        if (!rs) begin
            model_reset();
        end else begin
            if (fl) q1.delete();
            else begin
                if (drn) q1.delete(0);
                if (acc) q1.push_back(w);
            end
            rdy1 = (q1.size() < 2);
            drn = (q0.size() > 0) && o;
            acc = v && ((q0.size() == 0) || o);
            if (fl) q0.delete();
            else begin
                if (drn) q0.delete(0);
                if (acc) q0.push_back(w);
            end
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic fl,
                                input logic o, input logic ev, input logic [DW-1:0] ed,
                                input logic [1:0] eocc, input logic eir);
        vec_t r;
        r.v = v; r.d = d; r.fl = fl; r.o = o;
        r.ev = ev; r.ed = ed; r.eocc = eocc; r.eir = eir;
        return r;
    endfunction

    initial begin
        logic [127:0] rnd;

        // Rows for the SKID=1 instance; expectations are observed before the
        // edge that applies the row's inputs. Control is always 12'hFFF.
        //            v     d        fl    o     ev    ed       occ   ir
        tbl[0]  = mk(1'b1, 112'h5,  1'b0, 1'b0, 1'b0, 112'h0,  2'd0, 1'b1);
        tbl[1]  = mk(1'b1, 112'h6,  1'b0, 1'b0, 1'b1, 112'h5,  2'd1, 1'b1);
        tbl[2]  = mk(1'b1, 112'h7,  1'b0, 1'b0, 1'b1, 112'h5,  2'd2, 1'b0);
        tbl[3]  = mk(1'b1, 112'h7,  1'b0, 1'b0, 1'b1, 112'h5,  2'd2, 1'b0);
        tbl[4]  = mk(1'b1, 112'h7,  1'b0, 1'b1, 1'b1, 112'h5,  2'd2, 1'b0);
        tbl[5]  = mk(1'b1, 112'h7,  1'b0, 1'b1, 1'b1, 112'h6,  2'd1, 1'b1);
        tbl[6]  = mk(1'b0, 112'h0,  1'b0, 1'b1, 1'b1, 112'h7,  2'd1, 1'b1);
        tbl[7]  = mk(1'b0, 112'h0,  1'b0, 1'b0, 1'b0, 112'h0,  2'd0, 1'b1);
        tbl[8]  = mk(1'b1, 112'h21, 1'b0, 1'b0, 1'b0, 112'h0,  2'd0, 1'b1);
        tbl[9]  = mk(1'b1, 112'h22, 1'b0, 1'b0, 1'b1, 112'h21, 2'd1, 1'b1);
        tbl[10] = mk(1'b1, 112'h9,  1'b1, 1'b0, 1'b1, 112'h21, 2'd2, 1'b0);
        tbl[11] = mk(1'b0, 112'h0,  1'b0, 1'b1, 1'b0, 112'h0,  2'd0, 1'b1);
        tbl[12] = mk(1'b1, 112'h31, 1'b0, 1'b0, 1'b0, 112'h0,  2'd0, 1'b1);
        tbl[13] = mk(1'b1, 112'h9,  1'b1, 1'b0, 1'b1, 112'h31, 2'd1, 1'b1);
        tbl[14] = mk(1'b1, 112'h11, 1'b0, 1'b1, 1'b0, 112'h0,  2'd0, 1'b1);
        tbl[15] = mk(1'b0, 112'h0,  1'b1, 1'b1, 1'b1, 112'h11, 2'd1, 1'b1);
        tbl[16] = mk(1'b0, 112'h0,  1'b0, 1'b1, 1'b0, 112'h0,  2'd0, 1'b1);
        tbl[17] = mk(1'b0, 112'h0,  1'b0, 1'b1, 1'b0, 112'h0,  2'd0, 1'b1);

        // Reset held for three cycles: everything reads zero.
        for (int i = 0; i < 3; i++) begin
            sample();
            check("rst out_valid", 128'(r1_out_valid), 128'(0));
            check("rst out_data", 128'(r1_out_data), 128'(0));
            check("rst out_ctrl", 128'(r1_out_ctrl), 128'(0));
            check("rst occupancy", 128'(r1_occ), 128'(0));
            check("rst in_ready skid", 128'(r1_in_ready), 128'(0));
            check("rst out_ctrl single", 128'(r0_out_ctrl), 128'(0));
            advance();
        end
        rst_n = 1'b1;
        sample();
        check("release in_ready skid", 128'(r1_in_ready), 128'(0));
        check("release in_ready single", 128'(r0_in_ready), 128'(1));
        advance();

        // First entry after reset.
        in_valid = 1'b1; in_data = 112'h1234; in_ctrl = 12'hFFF; out_ready = 1'b1;
        sample();
        check("first in_ready", 128'(r1_in_ready), 128'(1));
        advance();
        in_valid = 1'b0;
        sample();
        check("first out_valid", 128'(r1_out_valid), 128'(1));
        check("first out_data", 128'(r1_out_data), 128'(112'h1234));
        check("first out_ctrl", 128'(r1_out_ctrl), 128'(12'hFFF));
        check("first occupancy", 128'(r1_occ), 128'(1));
        check("first out_data single", 128'(r0_out_data), 128'(112'h1234));
        advance();

        // Stall / skid fill / flush vectors.
        for (int i = 0; i < 18; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; in_ctrl = 12'hFFF;
            flush = tbl[i].fl; out_ready = tbl[i].o;
            sample();
            check($sformatf("vec%0d out_valid", i), 128'(r1_out_valid), 128'(tbl[i].ev));
            if (tbl[i].ev)
                check($sformatf("vec%0d out_data", i), 128'(r1_out_data), 128'(tbl[i].ed));
            check($sformatf("vec%0d out_ctrl", i), 128'(r1_out_ctrl),
                  128'(tbl[i].ev ? 12'hFFF : 12'hF19));
            check($sformatf("vec%0d occupancy", i), 128'(r1_occ), 128'(tbl[i].eocc));
            check($sformatf("vec%0d in_ready", i), 128'(r1_in_ready), 128'(tbl[i].eir));
            advance();
        end
        flush = 1'b0;

        // Back-to-back throughput: 0..99 in, 0..99 out, one per cycle.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            in_data = DW'(k); in_ctrl = CW'(k);
            sample();
            check("tput in_ready skid", 128'(r1_in_ready), 128'(1));
            check("tput in_ready single", 128'(r0_in_ready), 128'(1));
            if (k > 0) begin
                check("tput out_data skid", 128'(r1_out_data), 128'(k - 1));
                check("tput out_data single", 128'(r0_out_data), 128'(k - 1));
            end
            advance();
        end
        in_valid = 1'b0;
        sample();
        check("tput last skid", 128'(r1_out_data), 128'(99));
        check("tput last single", 128'(r0_out_data), 128'(99));
        advance();

        // Asynchronous reset in the middle of a stall with two entries held.
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'hFFF;
        in_data = 112'h41; sample(); advance();
        in_data = 112'h42; sample(); advance();
        sample();
        check("stall occupancy", 128'(r1_occ), 128'(2));
        advance();
        #1 rst_n = 1'b0;
        #1;
        check("async out_valid", 128'(r1_out_valid), 128'(0));
        check("async out_ctrl", 128'(r1_out_ctrl), 128'(0));
        check("async occupancy", 128'(r1_occ), 128'(0));
        check("async out_ctrl single", 128'(r0_out_ctrl), 128'(0));
        model_reset();
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("post-rst out_valid", 128'(r1_out_valid), 128'(0));
            advance();
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = rnd[DW-1:0];
            in_ctrl   = rnd[127:116];
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            sample();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/idex_pipe_stage.md
Name: idex_pipe_stage

Overview:
- Parametrised successor to the fixed-field ID/EX pipeline register.
- Carries a generic payload and control vector from decode to execute with a valid/ready handshake, stall back-pressure and synchronous flush that inserts a bubble.
- An optional two-entry skid buffer registers the ready path.
- Instantiated between ID and EX; the same block is reusable for EX/MEM and MEM/WB.

Parameters:
- DATA_W, 112, payload width (ReadData1/2, immExt, PCAddResult, rt, rd packed by the instantiating stage)
- CTRL_W, 12, control vector width (RegDst, Branch, MemRead, MemtoReg, ALUOp[3:0], MemWrite, ALUSrc, RegWrite, CondMov)
- KILL_MASK, 12'h0E6, control bits forced to 0 whenever the output is not valid (side-effecting bits)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready

Ports:
- Clk  input  1  clock, rising-edge
- Rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  ID has a valid instruction
- in_ready  output  1  stage can accept this cycle
- in_data  input  DATA_W  ID payload
- in_ctrl  input  CTRL_W  ID control vector
- flush  input  1  synchronous kill of all held entries (branch taken / hazard)
- out_valid  output  1  EX entry valid
- out_ready  input  1  EX consumes this cycle (0 = stall)
- out_data  output  DATA_W  EX payload
- out_ctrl  output  CTRL_W  EX control, KILL_MASK bits gated by out_valid
- occupancy  output  2  entries held (0..2; max 1 when SKID=0)

Behaviour:
- Reset (Rst_n=0, asynchronous): main and skid valid=0; data and ctrl registers=0; out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
- in_ready after reset:
  - SKID=1: in_ready=1 one cycle after reset release.
  - SKID=0: in_ready=1 immediately after reset release.
- Transfer definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Latency: an accepted entry appears on out_* the next cycle when the stage was empty or draining.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On accept: main <= in_* and valid=1.
  - On drain without accept: valid=0.
- SKID=1, main register M and skid register S:
  - in_ready = !S.valid (registered).
  - accept & (!M.valid | drain) & !S.valid: M <= in.
  - accept & M.valid & !drain: S <= in.
  - drain & S.valid: M <= S; S.valid=0.
  - drain & !S.valid & !accept: M.valid=0.
  - Ordering is preserved in all cases: S is always younger than M.
- Flush (synchronous, highest priority):
  - Next cycle, M.valid=S.valid=0.
  - Any input offered in the flush cycle is dropped; in_ready is unaffected in that cycle.
  - Data registers need not clear.
- Bubble rule: out_ctrl = ctrl_reg & ~(out_valid ? 0 : KILL_MASK). A non-valid stage never asserts RegWrite, MemWrite, MemRead, Branch or CondMov.
- Stall: while out_ready=0 with M.valid, out_data and out_ctrl hold stable (no change for any input).
- Simultaneous cases:
  - Flush together with drain: the drain completes and EX sees it; state still clears.
  - Flush together with accept: the accept is dropped.
  - Reset mid-transfer: all entries are lost; no output change until a new accept.
- Occupancy = M.valid + S.valid, registered.

Decomposition:
- Shared package pipe_pkg:
  - Control bit index constants (CTRL_REGDST ... CTRL_CONDMOV).
  - CTRL_W.
  - Default KILL_MASK built from those constants.
  - Payload field offsets for ID/EX.
- One natural sub-module, pipe_skid_reg: a single valid+data register with load/clear enables, instantiated as M and S.
- The top level holds the handshake and flush control logic.

Test Plan:
- Reset then single entry: Rst_n low 3 cycles → all outputs 0. Release, SKID=1, in_valid=1, in_data=112'h1234, in_ctrl=12'hFFF, out_ready=1 → next cycle out_valid=1, out_data=112'h1234, out_ctrl=12'hFFF, occupancy=1.
- Stall and skid fill: out_ready=0; push A=5 then B=6 → out_data holds 5, occupancy=2, in_ready=0. Third push C=7 is not accepted. Then out_ready=1 → outputs 5, then 6, then C is accepted.
- Flush bubble: two entries held, flush=1 for one cycle with in_valid=1 (D=9) → next cycle out_valid=0, occupancy=0, out_ctrl & 12'h0E6 = 0; D never appears.
- Flush with drain: M=0x11 valid, out_ready=1, flush=1 → EX samples 0x11 in that cycle; next cycle out_valid=0.
- Back-to-back throughput: out_ready=1 constantly, 100 sequential values 0..99 at in_valid=1 → outputs 0..99 in order, one per cycle, in_ready never low, for both SKID=0 and SKID=1.
- Async reset mid-stall: occupancy=2, Rst_n pulsed low between edges → out_valid=0 and out_ctrl=0 immediately without a clock edge; after release no stale entries emerge.
